dma_xfer_ctrl: RTL
==================

// Module: dma_xfer_ctrl
// PURPOSE
//  Memory-to-memory DMA engine; the upstream requester of the DMA/TDSP bus arbiter.
//  Programmed with source, destination and word count, then pulsed to start.
//  Raises dma_breq and moves words only while dma_grant is high.
//  Drops the request every BURST_LEN words so the TDSP can win the bus.
// PARAMETERS
//  ADDR_W     16  bus address width
//  DATA_W     16  bus data width
//  CNT_W       8  word-count width; max transfer is 2**CNT_W-1 words
//  BURST_LEN   4  words moved per grant before the request is released (>=1)
// PORTS
//  clk        in   1       system clock, all flops on rising edge
//  reset      in   1       asynchronous, active-low (0 = reset) system reset
//  cfg_src    in   ADDR_W  source start address, sampled on start
//  cfg_dst    in   ADDR_W  destination start address, sampled on start
//  cfg_cnt    in   CNT_W   words to move, sampled on start
//  start      in   1       one-cycle pulse; ignored while busy=1
//  dma_breq   out  1       bus request to the arbiter
//  dma_grant  in   1       registered bus grant from the arbiter
//  bus_addr   out  ADDR_W  bus address, valid with bus_rd or bus_wr
//  bus_rd     out  1       read strobe; bus_rdata is valid the following cycle
//  bus_wr     out  1       write strobe
//  bus_wdata  out  DATA_W  write data
//  bus_rdata  in   DATA_W  read data
//  busy       out  1       high from the start cycle+1 until done
//  done       out  1       one-cycle pulse when the last word has been written
// BEHAVIOUR
//  Reset: every output is 0, state is IDLE, and all counters and address registers are 0.
//  All outputs come straight from registers. There is no combinational path from input to output.
//  States:
//   IDLE:  start & cfg_cnt!=0 -> REQ. Latch src, dst and cnt; clear burst_cnt; busy=1.
//          start & cfg_cnt==0 -> DONE. The bus is never requested.
//   REQ:   dma_breq=1. dma_grant=1 -> RD.
//   RD:    bus_rd=1, bus_addr=src -> RCAP.
//   RCAP:  capture bus_rdata into the data buffer -> WR.
//   WR:    bus_wr=1, bus_addr=dst, bus_wdata=buffer.
//          On exit: src+1, dst+1, cnt-1, burst_cnt+1.
//          cnt becomes 0 -> DONE.
//          else burst_cnt==BURST_LEN -> YIELD.
//          else -> RD.
//   YIELD: dma_breq=0. Stay until dma_grant==0, then clear burst_cnt -> REQ.
//          The arbiter's registered grant falls one cycle after the request drops.
//   DONE:  dma_breq=0, done=1 for one cycle, busy=0 -> IDLE.
//  dma_breq is 1 in REQ, RD, RCAP and WR. It is 0 in IDLE, YIELD and DONE.
//  bus_rd and bus_wr are never both high. Neither is high unless dma_grant was high
//  in the same cycle.
//  Grant lost in RD, RCAP or WR (dma_grant=0 while dma_breq=1):
//   - abandon the current word and go to REQ;
//   - src, dst and cnt do not advance, so the word is replayed from RD;
//   - burst_cnt is kept.
//  Address counters wrap modulo 2**ADDR_W with no error.
//  start while busy is ignored and has no effect on the latched config.
//  reset asserted mid-transfer: return to IDLE at once, drop dma_breq and the strobes,
//  and give no done pulse.
//  Throughput: 3 cycles per word while granted. Each BURST_LEN boundary costs at least 3
//  extra cycles (YIELD, arbiter CLEAR/DMA_PRI, REQ).
// STRUCTURE
//  Shared include dma_defs.vh holds:
//   - the state encodings DMA_IDLE, DMA_REQ, DMA_RD, DMA_RCAP, DMA_WR, DMA_YIELD, DMA_DONE
//     as a 3-bit encoding;
//   - the default widths.
//  One sub-module, dma_addr_cnt: a loadable ADDR_W incrementer with enable, instanced
//  twice (src and dst).
//  The FSM, the count and burst counters and the data buffer stay in the top module.
// TESTING
//  1. src=0x0100 dst=0x0200 cnt=3, grant 1 cycle after breq:
//     -> reads 0x0100-0x0102, writes 0x0200-0x0202 with matching data;
//        done pulses once; dma_breq falls after the 3rd write.
//  2. cnt=9, BURST_LEN=4:
//     -> dma_breq drops after words 4 and 8 and is re-raised only after dma_grant=0;
//        9 writes total; done pulses once.
//  3. Real arbiter, tdsp_breq held high during the first YIELD:
//     -> DMA waits in REQ with no strobes until tdsp_breq is released,
//        then resumes at word 5 with no skipped or duplicated address.
//  4. Force dma_grant=0 during RCAP of word 2:
//     -> word 2 is re-read from the same src address after regrant;
//        the dst write sequence has no gaps.
//  5. start with cfg_cnt=0 -> done 2 cycles later; dma_breq stays 0 throughout.
//     start pulsed while busy -> ignored.
//  6. reset=0 during WR of word 2 of 5:
//     -> all outputs are 0 asynchronously; no done pulse;
//        a fresh start after release runs normally.
//     src=0xFFFF, cnt=2 -> reads 0xFFFF then 0x0000.

Source files
------------

// File: rtl/dma_xfer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dma_xfer_ctrl_pkg
// Shared definitions for the memory-to-memory DMA engine:
//   - default bus / count widths and burst length
//   - 3-bit FSM state encoding (also visible on the debug state port)
// No ports (package).
// -----------------------------------------------------------------------------
package dma_xfer_ctrl_pkg;

    localparam int DMA_ADDR_W    = 16;
    localparam int DMA_DATA_W    = 16;
    localparam int DMA_CNT_W     = 8;
    localparam int DMA_BURST_LEN = 4;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_REQ   = 3'd1,
        DMA_RD    = 3'd2,
        DMA_RCAP  = 3'd3,
        DMA_WR    = 3'd4,
        DMA_YIELD = 3'd5,
        DMA_DONE  = 3'd6
    } dma_state_t;

endpackage

// File: rtl/dma_xfer_ctrl_addr_cnt.sv
// -----------------------------------------------------------------------------
// dma_xfer_ctrl_addr_cnt
// Loadable W-bit address incrementer with enable. Wraps modulo 2**W.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   load         load load_val on this edge (has priority over en)
//   load_val     value to load
//   en           increment on this edge
//   next_q       value the counter will hold after this edge; lets the owner
//                register an address in the same cycle the counter moves
// -----------------------------------------------------------------------------
module dma_xfer_ctrl_addr_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] next_q
);

    logic [W-1:0] q;

    always_comb begin
        next_q = q;
        if (load)
            next_q = load_val;
        else if (en)
            next_q = q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else
            q <= next_q;
    end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// dma_xfer_ctrl
// Memory-to-memory DMA engine, upstream requester of the DMA/TDSP arbiter.
// Copies cfg_cnt words from cfg_src.. to cfg_dst.., one read + one write per
// word (3 cycles per word while granted), releasing the bus every BURST_LEN
// words so the other master can win arbitration.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cfg_src/dst/cnt       transfer config, sampled on an accepted start
//   start                 one-cycle start pulse, ignored unless idle
//   dma_breq / dma_grant  bus request out, registered grant in
//   bus_addr/rd/wr/wdata  bus master outputs; bus_rdata is valid the cycle
//   bus_rdata             after bus_rd
//   busy, done            transfer in progress / one-cycle completion pulse
//   dbg_state             current FSM state (dma_state_t encoding)
// Handshake: a strobe (bus_rd/bus_wr) is only issued when the FSM moved into
// RD/WR on an edge where dma_grant was sampled high; the bus accepts every
// strobe in the cycle it is presented (no ready/back-pressure).
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module dma_xfer_ctrl
    import dma_xfer_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DMA_ADDR_W,
    parameter int DATA_W    = DMA_DATA_W,
    parameter int CNT_W     = DMA_CNT_W,
    parameter int BURST_LEN = DMA_BURST_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [CNT_W-1:0]  cfg_cnt,
    input  logic              start,
    output logic              dma_breq,
    input  logic              dma_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int              BC_W       = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    dma_state_t        state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [BC_W-1:0]   burst_cnt;
    logic [BC_W-1:0]   burst_inc;
    logic [DATA_W-1:0] data_buf;
    logic [ADDR_W-1:0] src_next, dst_next;
    logic              accept, advance, yield_exit;

    logic              breq_d, rd_d, wr_d, busy_d, done_d;
    logic [ADDR_W-1:0] addr_d;

    assign accept     = (state == DMA_IDLE) && start;
    // A word only retires when its write completed under grant.
    assign advance    = (state == DMA_WR) && dma_grant;
    assign yield_exit = (state == DMA_YIELD) && !dma_grant;
    assign burst_inc  = burst_cnt + 1'b1;

    dma_xfer_ctrl_addr_cnt #(.W(ADDR_W)) u_src_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cfg_src),
        .en       (advance),
        .next_q   (src_next)
    );

    dma_xfer_ctrl_addr_cnt #(.W(ADDR_W)) u_dst_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cfg_dst),
        .en       (advance),
        .next_q   (dst_next)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= DMA_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. Losing grant in RD/RCAP/WR abandons the word; since
    // nothing advanced, the replay starts again from RD at the same address.
    always_comb begin
        next_state = state;
        case (state)
            DMA_IDLE:  if (start) next_state = (cfg_cnt != '0) ? DMA_REQ : DMA_DONE;
            DMA_REQ:   if (dma_grant) next_state = DMA_RD;
            DMA_RD:    next_state = dma_grant ? DMA_RCAP : DMA_REQ;
            DMA_RCAP:  next_state = dma_grant ? DMA_WR : DMA_REQ;
            DMA_WR: begin
                if (!dma_grant)
                    next_state = DMA_REQ;
                else if (cnt == CNT_LAST)
                    next_state = DMA_DONE;
                else if (burst_inc == BURST_LAST)
                    next_state = DMA_YIELD;
                else
                    next_state = DMA_RD;
            end
            DMA_YIELD: if (!dma_grant) next_state = DMA_REQ;
            DMA_DONE:  next_state = DMA_IDLE;
            default:   next_state = DMA_IDLE;
        endcase
    end

    // Output decode from next_state, registered below so outputs are flops.
    always_comb begin
        breq_d = (next_state == DMA_REQ) || (next_state == DMA_RD) ||
                 (next_state == DMA_RCAP) || (next_state == DMA_WR);
        rd_d   = (next_state == DMA_RD);
        wr_d   = (next_state == DMA_WR);
        busy_d = breq_d || (next_state == DMA_YIELD);
        done_d = (next_state == DMA_DONE);
        addr_d = '0;
        if (rd_d)
            addr_d = src_next;
        else if (wr_d)
            addr_d = dst_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_breq <= 1'b0;
            bus_rd   <= 1'b0;
            bus_wr   <= 1'b0;
            bus_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            dma_breq <= breq_d;
            bus_rd   <= rd_d;
            bus_wr   <= wr_d;
            bus_addr <= addr_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Word count, burst count and read-data buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            burst_cnt <= '0;
            data_buf  <= '0;
        end else begin
            if (accept)
                cnt <= cfg_cnt;
            else if (advance)
                cnt <= cnt - 1'b1;

            if (accept || yield_exit)
                burst_cnt <= '0;
            else if (advance)
                burst_cnt <= burst_inc;

            if (state == DMA_RCAP)
                data_buf <= bus_rdata;
        end
    end

    assign bus_wdata = data_buf;
    assign dbg_state = state;

endmodule
